// File: rtl/weakbus_arbiter.sv
// weakbus_arbiter: shares one weakcore-style req/ack memory bus between master 0 (core)
// and master 1 (DMA/debug/loader). The grant is registered: a request reaches the slave
// one cycle later. The grant is held until the slave acks, and an IDLE cycle always follows.
// Ties are broken round-robin (FIXED_PRIO=0) or always in favour of master 0 (FIXED_PRIO=1).
// Optional feature macro: WEAKBUS_TIMEOUT_EN. It adds a grant timeout of TIMEOUT cycles and
// a sticky timeout_flag. Without it timeout_flag is tied low and a grant waits indefinitely.
module weakbus_arbiter #(
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_wr,
    input  logic [3:0]  m0_wr_mask,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_wr,
    input  logic [3:0]  m1_wr_mask,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,

    output logic        s_req,
    output logic [31:0] s_addr,
    output logic        s_wr,
    output logic [3:0]  s_wr_mask,
    output logic [31:0] s_wdata,
    input  logic        s_ack,
    input  logic [31:0] s_rdata,

    output logic        timeout_flag
);

    localparam logic [31:0] TmoRdata = 32'hDEAD_BEEF;

    if (FIXED_PRIO > 1) begin : g_bad_prio
        $error("weakbus_arbiter: FIXED_PRIO must be 0 or 1");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("weakbus_arbiter: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StGnt0 = 2'b01,
        StGnt1 = 2'b10
    } state_t;

    state_t state_q, state_d;
    // Master that received the most recent grant; resets to 1 so master 0 wins the first tie.
    logic   last_q, last_d;

    logic        grant_active;
    logic        grant_sel;
    logic        sel_req;
    logic [31:0] sel_addr;
    logic        sel_wr;
    logic [3:0]  sel_wr_mask;
    logic [31:0] sel_wdata;
    logic        tmo_hit;
    logic        fwd_ack;
    logic [31:0] fwd_rdata;

    // Decode the grant. Reset low hides the grant at once, so an in-flight
    // transaction is dropped in the reset cycle itself.
    always_comb begin
        grant_active = rst && (state_q != StIdle);
        grant_sel    = (state_q == StGnt1);
    end

    // Select the request fields of the granted master.
    always_comb begin
        if (grant_sel) begin
            sel_req     = m1_req;
            sel_addr    = m1_addr;
            sel_wr      = m1_wr;
            sel_wr_mask = m1_wr_mask;
            sel_wdata   = m1_wdata;
        end else begin
            sel_req     = m0_req;
            sel_addr    = m0_addr;
            sel_wr      = m0_wr;
            sel_wr_mask = m0_wr_mask;
            sel_wdata   = m0_wdata;
        end
    end

`ifdef WEAKBUS_TIMEOUT_EN
    localparam logic [7:0] TmoCount = 8'(TIMEOUT);

    logic [7:0] age_q, age_d;
    logic       flag_q, flag_d;

    // Grant age counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            age_q  <= 8'd0;
            flag_q <= 1'b0;
        end else begin
            age_q  <= age_d;
            flag_q <= flag_d;
        end
    end

    // The age sits at 0 while idle, so the first grant cycle counts as 0.
    // A slave ack or a dropped request in the match cycle wins over the timeout.
    always_comb begin
        tmo_hit = grant_active && sel_req && !s_ack && (age_q == TmoCount);
        flag_d  = flag_q || tmo_hit;
        age_d   = age_q;
        if (state_q == StIdle) begin
            age_d = 8'd0;
        end else if (!s_ack) begin
            age_d = age_q + 8'd1;
        end
    end

    assign timeout_flag = flag_q;
`else
    assign tmo_hit      = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // Grant state and round-robin history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Arbitrate from IDLE. Release the grant on ack, on a dropped request, or on timeout.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (m0_req && m1_req) begin
                    if ((FIXED_PRIO != 0) || last_q) begin
                        state_d = StGnt0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = StGnt1;
                        last_d  = 1'b1;
                    end
                end else if (m0_req) begin
                    state_d = StGnt0;
                    last_d  = 1'b0;
                end else if (m1_req) begin
                    state_d = StGnt1;
                    last_d  = 1'b1;
                end
            end
            StGnt0, StGnt1: begin
                if (s_ack || !sel_req || tmo_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Completion seen by the granted master: the slave's ack, or a forced timeout ack.
    always_comb begin
        fwd_ack   = s_ack || tmo_hit;
        fwd_rdata = tmo_hit ? TmoRdata : s_rdata;
    end

    // Forward the granted master to the slave and route completion back to it alone.
    always_comb begin
        s_req     = 1'b0;
        s_addr    = 32'd0;
        s_wr      = 1'b0;
        s_wr_mask = 4'd0;
        s_wdata   = 32'd0;
        m0_ack    = 1'b0;
        m0_rdata  = 32'd0;
        m1_ack    = 1'b0;
        m1_rdata  = 32'd0;
        if (grant_active) begin
            s_req     = sel_req && !tmo_hit;
            s_addr    = sel_addr;
            s_wr      = sel_wr;
            s_wr_mask = sel_wr_mask;
            s_wdata   = sel_wdata;
            if (grant_sel) begin
                m1_ack   = fwd_ack;
                m1_rdata = fwd_rdata;
            end else begin
                m0_ack   = fwd_ack;
                m0_rdata = fwd_rdata;
            end
        end
    end

    // At most one master is ever acknowledged.
    a_single_ack: assert property (@(posedge clk) !(m0_ack && m1_ack));

endmodule

// File: doc/weakbus_arbiter.md
Name: weakbus_arbiter

Overview:
- Two-master arbiter sharing the single weakcore-style memory bus (req/ack, addr, wr, wr_mask, wdata, rdata) between master 0 (core) and master 1 (DMA/debug/loader).
- Sits between the masters and the memory/peripheral slave.
- Registered grant; round-robin or fixed-priority selection; grant locked until the slave acks.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin on tie; 1 = master 0 always wins a tie.
- TIMEOUT, 255: cycles without slave ack before forced completion (used only with WEAKBUS_TIMEOUT_EN); legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- m0_req  in  1  master 0 request
- m0_addr  in  32  master 0 address
- m0_wr  in  1  master 0 write
- m0_wr_mask  in  4  master 0 byte mask
- m0_wdata  in  32  master 0 write data
- m0_ack  out  1  master 0 completion pulse
- m0_rdata  out  32  master 0 read data
- m1_req, m1_addr, m1_wr, m1_wr_mask, m1_wdata, m1_ack, m1_rdata: same as master 0, for master 1
- s_req  out  1  slave request
- s_addr  out  32  slave address
- s_wr  out  1  slave write
- s_wr_mask  out  4  slave byte mask
- s_wdata  out  32  slave write data
- s_ack  in  1  slave completion
- s_rdata  in  32  slave read data
- timeout_flag  out  1  sticky timeout indicator

Behaviour:
- Reset rst, synchronous, active-low; clock clk.
- Reset: state IDLE, last_grant = 1 (so master 0 wins the first tie), timeout_flag = 0.
- Outputs at reset: all s_* = 0, m0_ack = m1_ack = 0, m0_rdata = m1_rdata = 0.
- Master protocol:
  - Master holds req and its addr/wr/mask/wdata stable until it sees ack.
  - ack is a one-cycle pulse; rdata is valid only in the ack cycle.
  - req high in the cycle after ack is a new transaction.
- States: IDLE, GNT0, GNT1.
- IDLE:
  - No master receives ack; all s_* outputs driven 0.
  - Only m0_req -> GNT0; only m1_req -> GNT1.
  - Both requesting, FIXED_PRIO=1 -> GNT0.
  - Both requesting, FIXED_PRIO=0 -> grant the master not equal to last_grant.
  - Entering GNTn sets last_grant = n.
- GNTn (combinational forwarding):
  - s_req = mn_req.
  - s_addr, s_wr, s_wr_mask, s_wdata = master n's signals.
  - mn_ack = s_ack; mn_rdata = s_rdata.
  - The other master sees ack 0 and rdata 0.
- GNTn transitions:
  - s_ack=1 -> IDLE.
  - mn_req=0 without ack (protocol violation) -> IDLE; no ack issued.
  - Otherwise stay; the grant is never preempted.
- Latency: request to s_req is 1 cycle; back-to-back transactions of one master are separated by at least 1 IDLE cycle.
- Fairness: with both masters requesting continuously under round-robin, grants alternate 0,1,0,1.
- s_ack received in IDLE is ignored.
- Reset mid-transaction: returns to IDLE at the next edge and the transaction is dropped; s_req falls that cycle.

Optional Feature:
- Macro: WEAKBUS_TIMEOUT_EN.
- Defined:
  - 8-bit counter clears on entry to GNTn and increments each GNTn cycle without s_ack.
  - When the counter equals TIMEOUT with s_ack still 0:
    - The arbiter asserts mn_ack for that cycle with mn_rdata = 32'hDEADBEEF.
    - s_req is forced to 0 in that cycle.
    - State -> IDLE; timeout_flag set to 1.
  - timeout_flag stays 1 until reset.
  - s_ack in the same cycle as the counter match takes precedence: normal completion, no flag.
- Undefined: no counter; timeout_flag is tied to 0; a grant waits indefinitely.

Test Plan:
- m0 read of addr 0x100 alone; slave acks 2 cycles after s_req with 0x12345678 -> s_req 1 cycle after m0_req, s_addr=0x100, m0_ack pulse with m0_rdata=0x12345678, m1_ack stays 0, state IDLE next cycle.
- m0 and m1 request simultaneously from reset, FIXED_PRIO=0, continuous requests -> grant order 0,1,0,1 over 4 transactions; FIXED_PRIO=1 -> master 0 every time.
- m1 write addr 0x200, wdata 0xCAFEF00D, mask 4'b0011, while m0 requests mid-grant -> s_* reflect m1 until s_ack, then m0 is granted after 1 IDLE cycle.
- rst low while in GNT1 with s_req high -> next cycle s_req=0, all outputs 0, no m1_ack; after reset a tie grants master 0.
- m0 drops req in GNT0 before s_ack -> IDLE next cycle, no m0_ack.
- WEAKBUS_TIMEOUT_EN, TIMEOUT=4, slave never acks m1 -> m1_ack on the 5th GNT1 cycle with rdata 0xDEADBEEF, timeout_flag=1 and stays 1; s_ack arriving on the match cycle -> normal completion, flag stays 0.
